// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register bank's single write port between
// the execute and load/store writeback paths, plus a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB0_VALID,
  output logic             WB0_READY,
  input  logic [AW-1:0]    WB0_ADDR,
  input  logic [WIDTH-1:0] WB0_DATA,
  input  logic             WB1_VALID,
  output logic             WB1_READY,
  input  logic [AW-1:0]    WB1_ADDR,
  input  logic [WIDTH-1:0] WB1_DATA,
  output logic             REGWRITE,
  output logic [AW-1:0]    ADR_WR_REG,
  output logic [WIDTH-1:0] WR_DATA,
  input  logic             SB_SET,
  input  logic [AW-1:0]    SB_SET_ADDR,
  input  logic [AW-1:0]    ADR_REG1,
  input  logic [AW-1:0]    ADR_REG2,
  output logic             BUSY1,
  output logic             BUSY2,
  output logic             GRANT_LAST
);

  logic             grant_last;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             ready0;
  logic             ready1;
  logic             xfer;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;

  // Grant depends only on the VALIDs and the last winner, never on ADDR/DATA.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (rst) begin
      if (WB0_VALID && WB1_VALID) begin
        ready0 = grant_last;
        ready1 = !grant_last;
      end else begin
        ready0 = WB0_VALID;
        ready1 = WB1_VALID;
      end
    end
  end

  assign WB0_READY  = ready0;
  assign WB1_READY  = ready1;
  assign GRANT_LAST = grant_last;
  assign xfer       = ready0 | ready1;
  assign win_addr   = ready1 ? WB1_ADDR : WB0_ADDR;
  assign win_data   = ready1 ? WB1_DATA : WB0_DATA;

  // Clear for the committing register first, then a new issue to it re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (xfer && (win_addr != '0)) busy_nxt[win_addr] = 1'b0;
    if (SB_SET && (SB_SET_ADDR != '0)) busy_nxt[SB_SET_ADDR] = 1'b1;
  end

  assign BUSY1 = busy[ADR_REG1];
  assign BUSY2 = busy[ADR_REG2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_last <= 1'b1;
      busy       <= '0;
      REGWRITE   <= 1'b0;
      ADR_WR_REG <= '0;
      WR_DATA    <= '0;
    end else begin
      busy     <= busy_nxt;
      REGWRITE <= xfer && (win_addr != '0);
      if (xfer) begin
        grant_last <= ready1;
        ADR_WR_REG <= win_addr;
        WR_DATA    <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a behavioural
// model of the grant order, committed writes and the busy scoreboard.
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             v0, v1, sb_set;
  logic [AW-1:0]    a0, a1, sb_addr, r1, r2;
  logic [WIDTH-1:0] d0, d1;
  logic             rdy0, rdy1, regwrite, busy1, busy2, gl;
  logic [AW-1:0]    adr_wr;
  logic [WIDTH-1:0] wr_data;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_busy[DEPTH];
  bit m_gl;
  int last_win;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .WB0_VALID(v0), .WB0_READY(rdy0), .WB0_ADDR(a0), .WB0_DATA(d0),
    .WB1_VALID(v1), .WB1_READY(rdy1), .WB1_ADDR(a1), .WB1_DATA(d1),
    .REGWRITE(regwrite), .ADR_WR_REG(adr_wr), .WR_DATA(wr_data),
    .SB_SET(sb_set), .SB_SET_ADDR(sb_addr),
    .ADR_REG1(r1), .ADR_REG2(r2), .BUSY1(busy1), .BUSY2(busy2),
    .GRANT_LAST(gl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_gl = 1'b1;
    last_win = -1;
  endtask

  // One clock: inputs are stable from the preceding falling edge.
  task automatic step();
    int win;
    int waddr;
    logic [WIDTH-1:0] wdata;
    #1;
    win = -1;
    if (v0 && v1)  win = m_gl ? 0 : 1;
    else if (v0)   win = 0;
    else if (v1)   win = 1;
    check("ready0", rdy0, win == 0);
    check("ready1", rdy1, win == 1);
    check("grant_last_pre", gl, m_gl);
    check("busy1", busy1, m_busy[r1]);
    check("busy2", busy2, m_busy[r2]);
    waddr = (win == 1) ? int'(a1) : int'(a0);
    wdata = (win == 1) ? d1 : d0;
    @(posedge clk);
    #1;
    last_win = win;
    if (win >= 0) begin
      m_gl = (win == 1);
      if (waddr != 0) m_busy[waddr] = 1'b0;
    end
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    check("regwrite", regwrite, (win >= 0) && (waddr != 0));
    if (win >= 0 && waddr != 0) begin
      check("adr_wr_reg", adr_wr, waddr);
      check("wr_data", wr_data, wdata);
    end
    check("grant_last_post", gl, m_gl);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = 5; a1 = 6; d0 = '0; d1 = '0;
    sb_set = 1'b0; sb_addr = '0; r1 = '0; r2 = '0;
    model_reset();
    #12;
    check("rst_regwrite", regwrite, 0);
    check("rst_adr", adr_wr, 0);
    check("rst_data", wr_data, 0);
    check("rst_grant_last", gl, 1);
    check("rst_ready0", rdy0, 0);
    check("rst_ready1", rdy1, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single write from WB0, then idle
    v1 = 1'b0; a0 = 5; d0 = 32'hDEADBEEF;
    step();
    v0 = 1'b0;
    step();

    // WB1 writes x0: handshake completes, write dropped
    v1 = 1'b1; a1 = 0; d1 = 32'h12345678; r1 = 0;
    step();
    v1 = 1'b0;
    step();

    // Contention: grants alternate, loser holds its request
    v0 = 1'b1; v1 = 1'b1; a0 = 1; a1 = 2; d0 = 32'h100; d1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_grant", last_win, i % 2);
      if (last_win == 0) d0++; else d1++;
    end
    v0 = 1'b0; v1 = 1'b0;
    step();

    // Scoreboard set, then cleared by a WB0 commit
    sb_set = 1'b1; sb_addr = 7;
    step();
    sb_set = 1'b0; r1 = 7;
    step();
    v0 = 1'b1; a0 = 7; d0 = 32'h77;
    step();
    v0 = 1'b0;
    step();

    // Same-cycle set and clear of x9: set wins
    sb_set = 1'b1; sb_addr = 9;
    step();
    v1 = 1'b1; a1 = 9; d1 = 32'h99; r2 = 9;
    step();
    sb_set = 1'b0; v1 = 1'b0;
    step();
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();

    // Reset during the commit cycle of a WB0 write
    sb_set = 1'b1; sb_addr = 4; r1 = 4;
    step();
    sb_set = 1'b0; v0 = 1'b1; a0 = 3; d0 = 32'h33;
    step();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b1; a1 = 6; d1 = 32'h66;
    model_reset();
    #1;
    check("midrst_regwrite", regwrite, 0);
    check("midrst_busy1", busy1, 0);
    check("midrst_busy2", busy2, 0);
    check("midrst_ready1", rdy1, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_win", last_win, 1);
    v1 = 1'b0;
    step();

    // Randomized traffic; a refused requester holds its request
    for (int i = 0; i < 400; i++) begin
      if (!(v0 && last_win != 0)) begin
        v0 = 1'($urandom_range(0, 1));
        a0 = v0 ? AW'($urandom_range(0, DEPTH - 1)) : 'x;
        d0 = v0 ? $urandom : 'x;
      end
      if (!(v1 && last_win != 1)) begin
        v1 = 1'($urandom_range(0, 1));
        a1 = v1 ? AW'($urandom_range(0, DEPTH - 1)) : 'x;
        d1 = v1 ? $urandom : 'x;
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, DEPTH - 1));
      r1      = AW'($urandom_range(0, DEPTH - 1));
      r2      = AW'($urandom_range(0, DEPTH - 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback sources: requester 0 (ALU/execute) and requester 1 (load/store unit).
- Round-robin arbitration with valid/ready handshakes. Winning writes are registered into one write command per cycle (REGWRITE, ADR_WR_REG, WR_DATA) for the register bank.
- Keeps a per-register busy scoreboard, set at issue and cleared at commit, so the issue stage can stall on RAW hazards against pending writebacks.

Parameters:
- WIDTH, 32, data width of a register.
- DEPTH, 32, number of registers; address width AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- WB0_VALID  in  1  requester 0 has a write.
- WB0_READY  out  1  requester 0 write accepted this cycle.
- WB0_ADDR  in  AW  requester 0 destination register.
- WB0_DATA  in  WIDTH  requester 0 write data.
- WB1_VALID  in  1  requester 1 has a write.
- WB1_READY  out  1  requester 1 write accepted this cycle.
- WB1_ADDR  in  AW  requester 1 destination register.
- WB1_DATA  in  WIDTH  requester 1 write data.
- REGWRITE  out  1  write enable to the register bank.
- ADR_WR_REG  out  AW  write address to the register bank.
- WR_DATA  out  WIDTH  write data to the register bank.
- SB_SET  in  1  issue stage marks a destination register as pending.
- SB_SET_ADDR  in  AW  register to mark busy.
- ADR_REG1  in  AW  source register 1 being issued.
- ADR_REG2  in  AW  source register 2 being issued.
- BUSY1  out  1  ADR_REG1 has a pending write.
- BUSY2  out  1  ADR_REG2 has a pending write.
- GRANT_LAST  out  1  requester granted most recently (debug).

Behaviour:
- Reset (rst low, asynchronous):
  - REGWRITE=0, ADR_WR_REG=0, WR_DATA=0.
  - All busy bits cleared.
  - GRANT_LAST=1, so requester 0 has priority first.
  - WBx_READY=0 while rst is low.
- Arbitration (combinational, single cycle):
  - Only one valid: that requester gets READY=1.
  - Both valid: grant the requester that is not GRANT_LAST; the other gets READY=0 and must hold VALID, ADDR and DATA stable.
  - Neither valid: both READY=0 and GRANT_LAST holds.
  - A transfer occurs when VALID & READY. GRANT_LAST updates to the granted index at the next rising edge.
  - READY never depends on the other requester's ADDR or DATA.
- Commit (registered, latency 1):
  - Transfer at edge N: REGWRITE=1, ADR_WR_REG and WR_DATA equal the winning ADDR and DATA during cycle N+1.
  - No transfer: REGWRITE=0 the next cycle; ADR_WR_REG and WR_DATA hold their last values.
  - Throughput is one write per cycle; back-to-back commits are allowed.
  - The register bank samples on the falling edge, so the write lands mid-cycle N+1.
- Register x0:
  - A transfer with ADDR=0 completes the handshake, but REGWRITE stays 0 the next cycle and the write is dropped.
  - The busy bit for x0 is never set; BUSY reads 0 for address 0.
- Scoreboard (one busy bit per register, DEPTH bits):
  - Set: SB_SET with SB_SET_ADDR≠0 sets that busy bit at the edge.
  - Clear: a transfer to address A≠0 clears bit A at the same edge as the transfer, so BUSY drops in cycle N+1 together with REGWRITE.
  - Set and clear of the same address in one cycle: set wins, because a new producer has been issued.
  - Set and clear of different addresses in one cycle: both take effect.
  - BUSY1 and BUSY2 are combinational reads of the current busy bits, with no bypass of a same-cycle clear.
- Boundaries:
  - Reset mid-operation: a transfer accepted before reset whose commit cycle falls in reset is lost (REGWRITE=0), and all busy bits are cleared.
  - Both requesters writing the same address in consecutive cycles: both commit in grant order, so the last committed value wins.
  - X/invalid ADDR while VALID=0 has no effect.

Test Plan:
- Reset, then WB0 writes x5=0xDEADBEEF alone → WB0_READY=1 in the same cycle; next cycle REGWRITE=1, ADR_WR_REG=5, WR_DATA=0xDEADBEEF; the following cycle REGWRITE=0.
- Both requesters valid continuously for 4 cycles (WB0→x1, WB1→x2, each incrementing data) → grants alternate 0,1,0,1 starting with 0; REGWRITE high 4 consecutive cycles; the non-granted requester sees READY=0 and its data is held.
- WB1 writes x0=0x12345678 → WB1_READY=1; next cycle REGWRITE=0; BUSY for x0 stays 0.
- SB_SET x7, then ADR_REG1=7 → BUSY1=1 until WB0 writes x7; BUSY1=0 in the commit cycle.
- SB_SET x9 in the same cycle as a WB transfer to x9 → BUSY stays 1 after the edge. A second WB to x9 → BUSY=0.
- WB0 transfer to x3, then rst asserted low before the next rising edge → REGWRITE=0 immediately and all BUSY=0. After release, WB1 alone is granted in one cycle and GRANT_LAST=1.
